// File: rtl/uart_baud_arbiter.sv
// Round-robin arbiter that shares one baud generator between N_REQ frame engines.
// Optional watchdog abort is built when UART_BAUD_ARB_WATCHDOG_EN is defined.
module uart_baud_arbiter #(
    parameter int N_REQ          = 2,
    parameter int CFG_SETUP      = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] req_tick,
    output logic [N_REQ-1:0] req_ready,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    input  logic [2:0]       cfg_baud_sl,
    output logic [2:0]       bg_baud_sl,
    output logic             bg_start,
    input  logic             bg_ready,
    input  logic             bg_finish,
    input  logic             bg_tick,
    output logic             busy,
    output logic [2:0]       dbg_state
);
    // Handshake: bg_start is a one-cycle pulse; the generator answers with a
    // one-cycle bg_ready, then ticks, then a one-cycle bg_finish. req is a level
    // held until done; ready/finish outside WAIT_RDY/ACTIVE are ignored.

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(CFG_SETUP + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        WAIT_RDY = 3'd3,
        ACTIVE   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    load_cnt_q, load_cnt_d;
    logic [2:0]       baud_q, baud_d;
    logic             timeout;
    logic [N_REQ-1:0] pick;
    logic             found;
    logic [PW-1:0]    gnt_idx;

    // First requester after rr_ptr, wrapping modulo N_REQ.
    always_comb begin : rr_pick
        logic [PW-1:0] sel;
        pick  = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sel = PW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        load_cnt_d = load_cnt_q;
        baud_d     = baud_q;
        case (state_q)
            IDLE: begin
                baud_d     = cfg_baud_sl;
                load_cnt_d = '0;
                if (found) begin
                    gnt_d   = pick;
                    state_d = LOAD;
                end
            end
            // The extra LOAD cycle lets the generator register the new baud select.
            LOAD: begin
                if (load_cnt_q == CW'(CFG_SETUP)) state_d = START;
                else load_cnt_d = load_cnt_q + CW'(1);
            end
            START:    state_d = WAIT_RDY;
            WAIT_RDY: if (bg_ready) state_d = ACTIVE;
            ACTIVE:   if (bg_finish) state_d = DONE;
            DONE: begin
                rr_ptr_d = gnt_idx;
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        if (timeout) state_d = DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= PW'(N_REQ - 1);
            load_cnt_q <= '0;
            baud_q     <= 3'b110;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            load_cnt_q <= load_cnt_d;
            baud_q     <= baud_d;
        end
    end

`ifdef UART_BAUD_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        wd_err_q, wd_err_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_err_d = wd_err_q;
        timeout  = 1'b0;
        if (state_q == START) begin
            wd_cnt_d = '0;
            wd_err_d = 1'b0;
        end else if (state_q == WAIT_RDY || state_q == ACTIVE) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
            if (wd_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                timeout  = 1'b1;
                wd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign err = (state_q == DONE) ? (gnt_q & {N_REQ{wd_err_q}}) : '0;
`else
    assign timeout = 1'b0;
    assign err     = '0;
`endif

    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign bg_start   = (state_q == START);
    assign bg_baud_sl = baud_q;
    assign req_ready  = (state_q == WAIT_RDY && bg_ready) ? gnt_q : '0;
    assign req_tick   = (state_q == ACTIVE && bg_tick) ? gnt_q : '0;
    assign done       = (state_q == DONE) ? gnt_q : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_baud_arbiter.sv
// Directed table-driven bench for uart_baud_arbiter (default build, watchdog off).
module tb_uart_baud_arbiter;
    localparam int SETUP = 2;

    typedef struct {
        logic [1:0] req;
        logic [2:0] cfg;
        int         ntick;
        logic [1:0] gnt;
        bit         drop;
        bit         keep;
    } slot_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = '0;
    logic [2:0] cfg_baud_sl = '0;
    logic       bg_ready = 1'b0;
    logic       bg_finish = 1'b0;
    logic       bg_tick = 1'b0;
    logic [1:0] gnt, req_tick, req_ready, done, err;
    logic [2:0] bg_baud_sl, dbg_state;
    logic       bg_start, busy;

    int n_total = 0;
    int n_bad = 0;
    slot_t tbl[9];

    always #5 clk = ~clk;

    uart_baud_arbiter #(.N_REQ(2), .CFG_SETUP(SETUP), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .req_tick(req_tick),
        .req_ready(req_ready), .done(done), .err(err), .cfg_baud_sl(cfg_baud_sl),
        .bg_baud_sl(bg_baud_sl), .bg_start(bg_start), .bg_ready(bg_ready),
        .bg_finish(bg_finish), .bg_tick(bg_tick), .busy(busy), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic run_slot(input slot_t s);
        logic [2:0] nc;
        nc = ~s.cfg;
        req = s.req;
        cfg_baud_sl = s.cfg;
        step();
        smp();
        chk("grant", gnt, s.gnt);
        chk("busy_load", busy, 1);
        chk("baud_capture", bg_baud_sl, s.cfg);
        for (int k = 1; k <= SETUP + 1; k++) begin
            step();
            bg_ready = 1'b0;
            bg_finish = 1'b0;
            if (k == 1) begin
                bg_ready = 1'b1;
                bg_finish = 1'b1;
                cfg_baud_sl = nc;
            end
            smp();
            chk("bg_start_timing", bg_start, (k == SETUP + 1));
            chk("ready_ignored_load", req_ready, 0);
            chk("baud_frozen", bg_baud_sl, s.cfg);
        end
        step();
        bg_finish = 1'b1;
        smp();
        chk("wait_busy", busy, 1);
        chk("ready_early", req_ready, 0);
        step();
        bg_finish = 1'b0;
        bg_ready = 1'b1;
        smp();
        chk("req_ready", req_ready, s.gnt);
        chk("bg_start_once", bg_start, 0);
        step();
        bg_ready = 1'b0;
        if (s.drop) req = 2'b00;
        for (int t = 0; t < s.ntick; t++) begin
            bg_tick = 1'b1;
            smp();
            chk("req_tick_on", req_tick, s.gnt);
            step();
            bg_tick = 1'b0;
            smp();
            chk("req_tick_off", req_tick, 0);
            step();
        end
        bg_finish = 1'b1;
        smp();
        chk("done_early", done, 0);
        step();
        bg_finish = 1'b0;
        if (!s.keep) req = 2'b00;
        smp();
        chk("done", done, s.gnt);
        chk("err", err, 0);
        chk("gnt_held", gnt, s.gnt);
        chk("baud_done", bg_baud_sl, s.cfg);
        step();
        smp();
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_done", done, 0);
        if (!s.keep) begin
            step();
            smp();
            chk("baud_deferred", bg_baud_sl, nc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // rr_ptr resets to 1, so the first contended grant goes to requester 0.
        tbl[0] = '{2'b01, 3'b110, 11, 2'b01, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 3'b000, 2,  2'b10, 1'b0, 1'b1};
        tbl[2] = '{2'b11, 3'b111, 1,  2'b01, 1'b0, 1'b1};
        tbl[3] = '{2'b11, 3'b011, 3,  2'b10, 1'b0, 1'b1};
        tbl[4] = '{2'b11, 3'b101, 0,  2'b01, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 3'b001, 2,  2'b10, 1'b1, 1'b0};
        tbl[6] = '{2'b10, 3'b010, 1,  2'b10, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 3'b100, 2,  2'b01, 1'b0, 1'b0};
        tbl[8] = '{2'b01, 3'b011, 2,  2'b01, 1'b0, 1'b0};

        smp();
        smp();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", bg_start, 0);
        chk("rst_baud", bg_baud_sl, 3'b110);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_tick", req_tick, 0);
        chk("rst_state", dbg_state, 0);
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_slot(tbl[i]);

        // Reset in the middle of an ACTIVE slot.
        req = 2'b01;
        cfg_baud_sl = 3'b000;
        step();
        for (int k = 1; k <= SETUP + 1; k++) step();
        step();
        bg_ready = 1'b1;
        step();
        bg_ready = 1'b0;
        bg_tick = 1'b1;
        smp();
        chk("pre_reset_tick", req_tick, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_tick", req_tick, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_baud", bg_baud_sl, 3'b110);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_done", done, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            smp();
            chk("rst_hold_done", done, 0);
        end
        req = 2'b00;
        bg_tick = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        run_slot('{2'b11, 3'b011, 2, 2'b01, 1'b0, 1'b0});
        run_slot('{2'b11, 3'b110, 1, 2'b10, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
